// File: rtl/ddr_frame_pkg.sv
// ddr_frame_pkg
//   Shared types for the DDR frame ping-pong controller.
//   - wr_state_t / rd_state_t : write and read sequencer states
//   - lock_t / BUF_NONE       : read-lock encoding ({none, buffer index})
//   - base()                  : buffer index to byte base address
package ddr_frame_pkg;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_ARM    = 2'd1,
    W_ACTIVE = 2'd2,
    W_DRAIN  = 2'd3
  } wr_state_t;

  typedef enum logic {
    R_IDLE   = 1'b0,
    R_ACTIVE = 1'b1
  } rd_state_t;

  // bit 1 set = no buffer locked, bit 0 = locked buffer index
  typedef logic [1:0] lock_t;
  localparam lock_t BUF_NONE = 2'b10;

  function automatic logic [29:0] base(input logic sel,
                                       input logic [29:0] b0,
                                       input logic [29:0] b1);
    return sel ? b1 : b0;
  endfunction

endpackage

// File: rtl/frame_wr_seq.sv
// frame_wr_seq
//   Write-side sequencer: claims a target buffer on frame start, publishes
//   the write address window, holds the write request through the frame and
//   the FIFO drain, and times out a drain that never empties.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   frame_start/end      sensor frame boundary pulses
//   fifo_empty           write-port input FIFO empty flag
//   rd_locked, rd_buf    read lock state from the read side
//   latest               index of the newest complete frame
//   claim, claim_tgt     buffer being claimed this cycle (clear its valid)
//   done, tgt            frame completed this cycle into buffer tgt
//   data_wr_req, new_wraddr_req, start_wr_addr, end_wr_addr  to memory i/f
//   drop_cnt             saturating count of ignored frame starts
//   drain_err            sticky drain timeout flag
module frame_wr_seq
  import ddr_frame_pkg::*;
#(
  parameter logic [29:0] BUF0_BASE     = 30'h0000000,
  parameter logic [29:0] BUF1_BASE     = 30'h0800000,
  parameter logic [29:0] FRAME_BYTES   = 30'h0400000,
  parameter logic [15:0] DRAIN_TIMEOUT = 16'd1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_start,
  input  logic        frame_end,
  input  logic        fifo_empty,
  input  logic        rd_locked,
  input  logic        rd_buf,
  input  logic        latest,
  output logic        claim,
  output logic        claim_tgt,
  output logic        done,
  output logic        tgt,
  output logic        data_wr_req,
  output logic        new_wraddr_req,
  output logic [29:0] start_wr_addr,
  output logic [29:0] end_wr_addr,
  output logic [15:0] drop_cnt,
  output logic        drain_err
);

  wr_state_t   state;
  logic [15:0] drain_cnt;
  logic        empty_seen;

  // A read accepted in this same cycle locks 'latest', so ~latest is also
  // the correct choice then; tgt can never land on a locked buffer.
  always_comb begin
    claim     = (state == W_IDLE) && frame_start;
    claim_tgt = rd_locked ? ~rd_buf : ~latest;
    done      = (state == W_DRAIN) && fifo_empty && empty_seen;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= W_IDLE;
      tgt            <= 1'b0;
      data_wr_req    <= 1'b0;
      new_wraddr_req <= 1'b0;
      start_wr_addr  <= '0;
      end_wr_addr    <= '0;
      drop_cnt       <= '0;
      drain_err      <= 1'b0;
      drain_cnt      <= '0;
      empty_seen     <= 1'b0;
    end else begin
      if (frame_start && (state != W_IDLE) && (drop_cnt != 16'hFFFF))
        drop_cnt <= drop_cnt + 16'd1;

      case (state)
        W_IDLE: begin
          if (claim) begin
            tgt            <= claim_tgt;
            start_wr_addr  <= base(claim_tgt, BUF0_BASE, BUF1_BASE);
            end_wr_addr    <= base(claim_tgt, BUF0_BASE, BUF1_BASE) + FRAME_BYTES - 30'd8;
            new_wraddr_req <= 1'b1;
            state          <= W_ARM;
          end
        end
        W_ARM: begin
          new_wraddr_req <= 1'b0;
          data_wr_req    <= 1'b1;
          state          <= W_ACTIVE;
        end
        W_ACTIVE: begin
          if (frame_end) begin
            drain_cnt  <= '0;
            empty_seen <= 1'b0;
            state      <= W_DRAIN;
          end
        end
        W_DRAIN: begin
          empty_seen <= fifo_empty;
          if (done) begin
            data_wr_req <= 1'b0;
            state       <= W_IDLE;
          end else if (drain_cnt == DRAIN_TIMEOUT - 16'd1) begin
            drain_err   <= 1'b1;
            data_wr_req <= 1'b0;
            state       <= W_IDLE;
          end else begin
            drain_cnt <= drain_cnt + 16'd1;
          end
        end
        default: state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ddr_frame_pingpong_ctrl.sv
// ddr_frame_pingpong_ctrl
//   okClk-side request sequencer for two DDR frame buffers. Sensor frames are
//   written to the buffer not held by the host; the host reads the newest
//   complete frame, which stays locked until the host reports done.
// Ports:
//   clk_i, rst_n_i                       okClk, async active-low reset
//   wr_frame_start_i, wr_frame_end_i     sensor frame boundary pulses
//   empty_inFIFO_i                       write-port FIFO empty flag
//   host_rd_start_i, host_rd_done_i      host read request / completion
//   data_wr_req_o, new_wraddr_req_o, start_wr_addr_o, end_wr_addr_o
//   data_rd_req_o, start_rd_addr_o, rd_len_o
//   rd_nack_o                            read request refused (no frame)
//   buf_valid_o                          per-buffer complete unread frame
//   drop_cnt_o, drain_err_o              status
module ddr_frame_pingpong_ctrl
  import ddr_frame_pkg::*;
#(
  parameter logic [29:0] BUF0_BASE     = 30'h0000000,
  parameter logic [29:0] BUF1_BASE     = 30'h0800000,
  parameter logic [29:0] FRAME_BYTES   = 30'h0400000,
  parameter logic [15:0] DRAIN_TIMEOUT = 16'd1024
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        wr_frame_start_i,
  input  logic        wr_frame_end_i,
  input  logic        empty_inFIFO_i,
  input  logic        host_rd_start_i,
  input  logic        host_rd_done_i,
  output logic        data_wr_req_o,
  output logic        new_wraddr_req_o,
  output logic [29:0] start_wr_addr_o,
  output logic [29:0] end_wr_addr_o,
  output logic        data_rd_req_o,
  output logic [29:0] start_rd_addr_o,
  output logic [29:0] rd_len_o,
  output logic        rd_nack_o,
  output logic [1:0]  buf_valid_o,
  output logic [15:0] drop_cnt_o,
  output logic        drain_err_o
);

  rd_state_t rd_state;
  lock_t     rd_lock;
  logic      latest;
  logic      rd_locked;
  logic      claim;
  logic      claim_tgt;
  logic      done;
  logic      wr_tgt;

  assign rd_locked = (rd_lock != BUF_NONE);

  frame_wr_seq #(
    .BUF0_BASE     (BUF0_BASE),
    .BUF1_BASE     (BUF1_BASE),
    .FRAME_BYTES   (FRAME_BYTES),
    .DRAIN_TIMEOUT (DRAIN_TIMEOUT)
  ) u_wr_seq (
    .clk            (clk_i),
    .rst_n          (rst_n_i),
    .frame_start    (wr_frame_start_i),
    .frame_end      (wr_frame_end_i),
    .fifo_empty     (empty_inFIFO_i),
    .rd_locked      (rd_locked),
    .rd_buf         (rd_lock[0]),
    .latest         (latest),
    .claim          (claim),
    .claim_tgt      (claim_tgt),
    .done           (done),
    .tgt            (wr_tgt),
    .data_wr_req    (data_wr_req_o),
    .new_wraddr_req (new_wraddr_req_o),
    .start_wr_addr  (start_wr_addr_o),
    .end_wr_addr    (end_wr_addr_o),
    .drop_cnt       (drop_cnt_o),
    .drain_err      (drain_err_o)
  );

  // Claim, completion and read release always touch different buffers, so
  // the per-bit updates below never collide. The read decision uses the
  // registered latest/valid, i.e. the state before a coincident completion.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_state        <= R_IDLE;
      rd_lock         <= BUF_NONE;
      latest          <= 1'b0;
      buf_valid_o     <= '0;
      data_rd_req_o   <= 1'b0;
      start_rd_addr_o <= BUF0_BASE;
      rd_len_o        <= '0;
      rd_nack_o       <= 1'b0;
    end else begin
      rd_nack_o <= 1'b0;

      if (claim)
        buf_valid_o[claim_tgt] <= 1'b0;
      if (done) begin
        buf_valid_o[wr_tgt] <= 1'b1;
        latest              <= wr_tgt;
      end

      case (rd_state)
        R_IDLE: begin
          if (host_rd_start_i) begin
            if (buf_valid_o[latest]) begin
              rd_lock         <= {1'b0, latest};
              start_rd_addr_o <= base(latest, BUF0_BASE, BUF1_BASE);
              rd_len_o        <= FRAME_BYTES;
              data_rd_req_o   <= 1'b1;
              rd_state        <= R_ACTIVE;
            end else begin
              rd_nack_o <= 1'b1;
            end
          end
        end
        R_ACTIVE: begin
          if (host_rd_done_i) begin
            buf_valid_o[rd_lock[0]] <= 1'b0;
            rd_lock                 <= BUF_NONE;
            data_rd_req_o           <= 1'b0;
            rd_state                <= R_IDLE;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_frame_pingpong_ctrl.sv
// tb_ddr_frame_pingpong_ctrl
//   Directed bench for ddr_frame_pingpong_ctrl with hand-computed expectations.
module tb_ddr_frame_pingpong_ctrl;

  logic        clk;
  logic        rst_n;
  logic        wr_frame_start;
  logic        wr_frame_end;
  logic        empty_in;
  logic        host_rd_start;
  logic        host_rd_done;
  logic        data_wr_req;
  logic        new_wraddr_req;
  logic [29:0] start_wr_addr;
  logic [29:0] end_wr_addr;
  logic        data_rd_req;
  logic [29:0] start_rd_addr;
  logic [29:0] rd_len;
  logic        rd_nack;
  logic [1:0]  buf_valid;
  logic [15:0] drop_cnt;
  logic        drain_err;

  int passed = 0;
  int total  = 0;

  ddr_frame_pingpong_ctrl #(
    .BUF0_BASE     (30'h0000000),
    .BUF1_BASE     (30'h0800000),
    .FRAME_BYTES   (30'h0400000),
    .DRAIN_TIMEOUT (16'd1024)
  ) dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .wr_frame_start_i (wr_frame_start),
    .wr_frame_end_i   (wr_frame_end),
    .empty_inFIFO_i   (empty_in),
    .host_rd_start_i  (host_rd_start),
    .host_rd_done_i   (host_rd_done),
    .data_wr_req_o    (data_wr_req),
    .new_wraddr_req_o (new_wraddr_req),
    .start_wr_addr_o  (start_wr_addr),
    .end_wr_addr_o    (end_wr_addr),
    .data_rd_req_o    (data_rd_req),
    .start_rd_addr_o  (start_rd_addr),
    .rd_len_o         (rd_len),
    .rd_nack_o        (rd_nack),
    .buf_valid_o      (buf_valid),
    .drop_cnt_o       (drop_cnt),
    .drain_err_o      (drain_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    rst_n          = 1'b0;
    wr_frame_start = 1'b0;
    wr_frame_end   = 1'b0;
    empty_in       = 1'b0;
    host_rd_start  = 1'b0;
    host_rd_done   = 1'b0;
    step();
    step();

    // reset state
    chk("rst_data_wr_req", {31'd0, data_wr_req}, 32'd0);
    chk("rst_new_wraddr",  {31'd0, new_wraddr_req}, 32'd0);
    chk("rst_start_wr",    {2'd0, start_wr_addr}, 32'h0);
    chk("rst_end_wr",      {2'd0, end_wr_addr}, 32'h0);
    chk("rst_data_rd_req", {31'd0, data_rd_req}, 32'd0);
    chk("rst_start_rd",    {2'd0, start_rd_addr}, 32'h0);
    chk("rst_rd_len",      {2'd0, rd_len}, 32'h0);
    chk("rst_nack",        {31'd0, rd_nack}, 32'd0);
    chk("rst_buf_valid",   {30'd0, buf_valid}, 32'd0);
    chk("rst_drop_cnt",    {16'd0, drop_cnt}, 32'd0);
    chk("rst_drain_err",   {31'd0, drain_err}, 32'd0);
    rst_n = 1'b1;
    step();

    // host read with nothing valid
    host_rd_start = 1'b1;
    step();
    host_rd_start = 1'b0;
    chk("nack_pulse",      {31'd0, rd_nack}, 32'd1);
    chk("nack_no_rd_req",  {31'd0, data_rd_req}, 32'd0);
    step();
    chk("nack_one_cycle",  {31'd0, rd_nack}, 32'd0);
    chk("nack_no_rd_req2", {31'd0, data_rd_req}, 32'd0);

    // frame 1 -> buffer 1
    empty_in       = 1'b1;
    wr_frame_start = 1'b1;
    step();
    wr_frame_start = 1'b0;
    chk("f1_new_wraddr",   {31'd0, new_wraddr_req}, 32'd1);
    chk("f1_start_wr",     {2'd0, start_wr_addr}, 32'h0800000);
    chk("f1_end_wr",       {2'd0, end_wr_addr}, 32'h0BFFFF8);
    chk("f1_arm_no_wrreq", {31'd0, data_wr_req}, 32'd0);
    step();
    chk("f1_new_wraddr_off", {31'd0, new_wraddr_req}, 32'd0);
    chk("f1_data_wr_req",  {31'd0, data_wr_req}, 32'd1);
    wr_frame_end = 1'b1;
    step();
    wr_frame_end = 1'b0;
    chk("f1_drain_wr_req", {31'd0, data_wr_req}, 32'd1);
    step();
    chk("f1_not_done_yet", {30'd0, buf_valid}, 32'd0);
    // completion cycle coincides with a host read: read sees pre-update state
    host_rd_start = 1'b1;
    step();
    host_rd_start = 1'b0;
    chk("f1_buf_valid",    {30'd0, buf_valid}, 32'b10);
    chk("f1_wr_req_drop",  {31'd0, data_wr_req}, 32'd0);
    chk("coinc_nack",      {31'd0, rd_nack}, 32'd1);
    chk("coinc_no_rd_req", {31'd0, data_rd_req}, 32'd0);

    // host read of buffer 1
    host_rd_start = 1'b1;
    step();
    host_rd_start = 1'b0;
    chk("rd_req",          {31'd0, data_rd_req}, 32'd1);
    chk("rd_start_addr",   {2'd0, start_rd_addr}, 32'h0800000);
    chk("rd_len",          {2'd0, rd_len}, 32'h0400000);
    chk("rd_no_nack",      {31'd0, rd_nack}, 32'd0);

    // frame 2 during the read -> buffer 0
    wr_frame_start = 1'b1;
    step();
    wr_frame_start = 1'b0;
    chk("f2_new_wraddr",   {31'd0, new_wraddr_req}, 32'd1);
    chk("f2_start_wr",     {2'd0, start_wr_addr}, 32'h0000000);
    chk("f2_end_wr",       {2'd0, end_wr_addr}, 32'h03FFFF8);
    chk("f2_buf1_kept",    {30'd0, buf_valid}, 32'b10);
    step();

    // three ignored starts while active
    for (int i = 0; i < 3; i++) begin
      wr_frame_start = 1'b1;
      step();
      wr_frame_start = 1'b0;
      chk("drop_no_wraddr", {31'd0, new_wraddr_req}, 32'd0);
      step();
    end
    chk("drop_cnt_3",      {16'd0, drop_cnt}, 32'd3);
    chk("drop_addr_kept",  {2'd0, start_wr_addr}, 32'h0000000);

    // host start ignored while reading
    host_rd_start = 1'b1;
    step();
    host_rd_start = 1'b0;
    chk("rd_busy_no_nack", {31'd0, rd_nack}, 32'd0);
    chk("rd_busy_addr",    {2'd0, start_rd_addr}, 32'h0800000);

    // frame 2 end with FIFO never draining
    empty_in     = 1'b0;
    wr_frame_end = 1'b1;
    step();
    wr_frame_end = 1'b0;
    for (int i = 0; i < 1023; i++) step();
    chk("drain_err_early", {31'd0, drain_err}, 32'd0);
    chk("drain_wr_req_on", {31'd0, data_wr_req}, 32'd1);
    step();
    chk("drain_err_set",   {31'd0, drain_err}, 32'd1);
    chk("drain_wr_req_off",{31'd0, data_wr_req}, 32'd0);
    chk("drain_buf0_inval",{30'd0, buf_valid}, 32'b10);
    step();
    chk("drain_err_sticky",{31'd0, drain_err}, 32'd1);

    // host done releases buffer 1
    host_rd_done = 1'b1;
    step();
    host_rd_done = 1'b0;
    chk("done_rd_req_off", {31'd0, data_rd_req}, 32'd0);
    chk("done_buf_clear",  {30'd0, buf_valid}, 32'b00);

    // frame 3 -> buffer 0 (latest is 1), then read it
    empty_in       = 1'b1;
    wr_frame_start = 1'b1;
    step();
    wr_frame_start = 1'b0;
    chk("f3_start_wr",     {2'd0, start_wr_addr}, 32'h0000000);
    step();
    wr_frame_end = 1'b1;
    step();
    wr_frame_end = 1'b0;
    step();
    step();
    chk("f3_buf_valid",    {30'd0, buf_valid}, 32'b01);
    host_rd_start = 1'b1;
    step();
    host_rd_start = 1'b0;
    chk("f3_rd_req",       {31'd0, data_rd_req}, 32'd1);
    chk("f3_rd_addr",      {2'd0, start_rd_addr}, 32'h0000000);

    // frame 4 in flight, then asynchronous reset mid-read
    wr_frame_start = 1'b1;
    step();
    wr_frame_start = 1'b0;
    chk("f4_start_wr",     {2'd0, start_wr_addr}, 32'h0800000);
    step();
    chk("f4_wr_req",       {31'd0, data_wr_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_rd_req",     {31'd0, data_rd_req}, 32'd0);
    chk("arst_wr_req",     {31'd0, data_wr_req}, 32'd0);
    chk("arst_buf_valid",  {30'd0, buf_valid}, 32'd0);
    chk("arst_rd_len",     {2'd0, rd_len}, 32'h0);
    chk("arst_start_wr",   {2'd0, start_wr_addr}, 32'h0);
    chk("arst_drop_cnt",   {16'd0, drop_cnt}, 32'd0);
    chk("arst_drain_err",  {31'd0, drain_err}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
